// File: rtl/cpu_ask2_adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ask2_adc_pkg
//  Purpose  : Shared definitions for the ADC SDI transmitter: Avalon-MM
//             register addresses, STATUS bit positions, counter widths and
//             the transmitter FSM state enumeration.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_ask2_adc_pkg;

    // Avalon-MM word addresses
    localparam logic [1:0] c_ADDR_TXDATA = 2'd0;
    localparam logic [1:0] c_ADDR_STATUS = 2'd1;

    // STATUS register bit positions
    localparam int unsigned c_STATUS_BUSY_BIT = 0;
    localparam int unsigned c_STATUS_OVR_BIT  = 1;

    // Half-period counter width; covers the full CLK_DIV range of 2..255
    localparam int unsigned c_HALF_CNT_W = 8;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_ask2_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ask2_sclk_gen
//  Purpose  : SCLK / bit timing for the ADC SDI transmitter. A half-period
//             counter marks the last cycle of every CLK_DIV-cycle interval;
//             when toggling is enabled the SCLK level flips at that point and
//             the matching rise/fall strobe is raised one cycle ahead of it.
//  Ports    : clk        - system clock
//             reset      - synchronous active-high reset
//             clear_i    - hold counter at zero and SCLK low
//             toggle_i   - allow SCLK to flip at the end of this interval
//             half_end_o - last cycle of the current CLK_DIV interval
//             rise_o     - SCLK goes high at the next edge
//             fall_o     - SCLK goes low at the next edge
//             sclk_o     - registered SCLK level
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_ask2_sclk_gen
    import cpu_ask2_adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic toggle_i,
    output logic half_end_o,
    output logic rise_o,
    output logic fall_o,
    output logic sclk_o
);

    localparam logic [c_HALF_CNT_W-1:0] c_HALF_LAST = c_HALF_CNT_W'(CLK_DIV - 1);

    logic [c_HALF_CNT_W-1:0] cnt_q, cnt_d;
    logic                    sclk_q, sclk_d;
    logic                    w_half_end;

    always_comb begin
        w_half_end = (cnt_q == c_HALF_LAST);
        cnt_d      = cnt_q;
        sclk_d     = sclk_q;
        if (clear_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else begin
            cnt_d = w_half_end ? '0 : cnt_q + c_HALF_CNT_W'(1);
            if (toggle_i && w_half_end) begin
                sclk_d = ~sclk_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign half_end_o = w_half_end;
    assign rise_o     = w_half_end & toggle_i & ~clear_i & ~sclk_q;
    assign fall_o     = w_half_end & toggle_i & ~clear_i &  sclk_q;
    assign sclk_o     = sclk_q;

endmodule
`default_nettype wire

// File: rtl/cpu_ask2_adc_sdi_tx.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ask2_adc_sdi_tx
//  Purpose  : Avalon-MM slave that serialises a DATA_W-bit word to an ADC,
//             MSB first. Frame: SETUP (cs low, sclk low), DATA_W bits of
//             sclk high/low, HOLD (cs low), GAP (cs high), each phase CLK_DIV
//             clk cycles long. Writes to TXDATA while busy are dropped and
//             flagged in the sticky overrun bit.
//  Ports    : clk, reset                     - clock, sync active-high reset
//             address, chipselect, write_n,
//             writedata                      - Avalon-MM write/address side
//             readdata                       - registered read data (1 cycle)
//             adc_cs_n, adc_sclk, adc_sdi    - ADC serial interface
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_ask2_adc_sdi_tx
    import cpu_ask2_adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DATA_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_sdi
);

    localparam int unsigned            c_BIT_W    = $clog2(DATA_W + 1);
    localparam logic [c_BIT_W-1:0]     c_LAST_BIT = c_BIT_W'(DATA_W);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   txdata_q, txdata_d;
    logic [c_BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic                overrun_q, overrun_d;
    logic [31:0]         readdata_q, readdata_d;

    logic w_wr, w_wr_tx, w_wr_status;
    logic w_half_end, w_rise, w_fall, w_sclk;
    logic w_gen_clear, w_gen_toggle, w_last_low;
    logic w_busy, w_cs_active;
    logic w_unused;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_tx     = w_wr & (address == c_ADDR_TXDATA);
    assign w_wr_status = w_wr & (address == c_ADDR_STATUS);

    // Low phase of the final bit: the edge closing it must not raise SCLK
    // again, it hands over to HOLD instead.
    assign w_last_low   = (state_q == ST_SHIFT) & ~w_sclk & (bitcnt_q == c_LAST_BIT);
    assign w_gen_clear  = (state_q == ST_IDLE);
    // SETUP's closing edge produces the first rising SCLK edge.
    assign w_gen_toggle = (state_q == ST_SETUP) | ((state_q == ST_SHIFT) & ~w_last_low);

    cpu_ask2_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (w_gen_clear),
        .toggle_i   (w_gen_toggle),
        .half_end_o (w_half_end),
        .rise_o     (w_rise),
        .fall_o     (w_fall),
        .sclk_o     (w_sclk)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (w_wr_tx)                 state_d = ST_SETUP;
            ST_SETUP: if (w_half_end)              state_d = ST_SHIFT;
            ST_SHIFT: if (w_half_end && w_last_low) state_d = ST_HOLD;
            ST_HOLD:  if (w_half_end)              state_d = ST_GAP;
            ST_GAP:   if (w_half_end)              state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy      = (state_q != ST_IDLE);
        w_cs_active = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
        adc_cs_n    = ~w_cs_active;
        adc_sclk    = w_sclk;
        adc_sdi     = w_cs_active & shreg_q[DATA_W-1];
    end

    // ---------------- datapath and register file ----------------
    always_comb begin
        txdata_d = txdata_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        if ((state_q == ST_IDLE) && w_wr_tx) begin
            txdata_d = writedata[DATA_W-1:0];
            shreg_d  = writedata[DATA_W-1:0];
            bitcnt_d = '0;
        end else if ((state_q == ST_SHIFT) && w_fall) begin
            // Data advances on the falling SCLK edge so the ADC samples a
            // stable bit on every rising edge.
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q + c_BIT_W'(1);
        end

        // Set has priority over a W1C clear landing in the same cycle.
        overrun_d = overrun_q;
        if (w_wr_status && writedata[c_STATUS_OVR_BIT]) begin
            overrun_d = 1'b0;
        end
        if (w_wr_tx && w_busy) begin
            overrun_d = 1'b1;
        end

        readdata_d = '0;
        case (address)
            c_ADDR_TXDATA: readdata_d[DATA_W-1:0] = txdata_q;
            c_ADDR_STATUS: begin
                readdata_d[c_STATUS_BUSY_BIT] = w_busy;
                readdata_d[c_STATUS_OVR_BIT]  = overrun_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q    <= '0;
            txdata_q   <= '0;
            bitcnt_q   <= '0;
            overrun_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            shreg_q    <= shreg_d;
            txdata_q   <= txdata_d;
            bitcnt_q   <= bitcnt_d;
            overrun_q  <= overrun_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

    // Upper writedata bits and the rise strobe have no consumer here.
    assign w_unused = &{1'b0, writedata, w_rise};

endmodule
`default_nettype wire

// File: tb/tb_cpu_ask2_adc_sdi_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_ask2_adc_sdi_tx
//  Purpose  : Scoreboard bench for cpu_ask2_adc_sdi_tx. Bus tasks update a
//             transaction-level model (busy window, TXDATA, overrun) and push
//             expected read data / transmitted words; monitors pop and compare
//             when the DUT presents read data or completes a frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_ask2_adc_sdi_tx;

    localparam int D     = 4;
    localparam int W     = 16;
    localparam int BUSY  = D * (2 * W + 3);
    localparam int CSLOW = D * (2 * W + 2);
    localparam int D2    = 2;
    localparam int BUSY2 = D2 * (2 * W + 3);

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        adc_cs_n, adc_sclk, adc_sdi;

    logic [1:0]  address2;
    logic        chipselect2, write_n2;
    logic [31:0] writedata2;
    logic [31:0] readdata2;
    logic        cs2, sclk2, sdi2;

    cpu_ask2_adc_sdi_tx #(.CLK_DIV(D), .DATA_W(W)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_sdi(adc_sdi)
    );

    cpu_ask2_adc_sdi_tx #(.CLK_DIV(D2), .DATA_W(W)) dut2 (
        .clk(clk), .reset(reset), .address(address2), .chipselect(chipselect2),
        .write_n(write_n2), .writedata(writedata2), .readdata(readdata2),
        .adc_cs_n(cs2), .adc_sclk(sclk2), .adc_sdi(sdi2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_tx    = '0;
    bit          m_ovr   = 1'b0;
    int          m_start = -1000;
    int          m_end   = -1000;

    // Busy as seen by a register sample taken at clock edge j, for a
    // transfer accepted at edge m_start.
    function automatic bit m_busy_at(input int j);
        return (j > m_start) && (j <= m_end);
    endfunction

    typedef struct {
        int          at_edge;
        logic [1:0]  a;
        logic [31:0] exp;
    } rd_t;

    rd_t         rd_q[$];
    logic [15:0] exp_words[$];

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input bit cs);
        int j;
        @(negedge clk);
        address = a; writedata = d; chipselect = cs; write_n = 1'b0;
        j = cyc + 1;
        if (cs && a == 2'd0) begin
            if (m_busy_at(j)) begin
                m_ovr = 1'b1;
            end else begin
                m_tx    = d[15:0];
                m_start = j;
                m_end   = j + BUSY;
                exp_words.push_back(d[15:0]);
            end
        end else if (cs && a == 2'd1 && d[1]) begin
            m_ovr = 1'b0;
        end
        @(posedge clk);
        #1;
        write_n = 1'b1; chipselect = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        rd_t r;
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        r.at_edge = cyc + 1;
        r.a       = a;
        case (a)
            2'd0:    r.exp = {16'h0, m_tx};
            2'd1:    r.exp = {30'h0, m_ovr, m_busy_at(r.at_edge)};
            default: r.exp = 32'h0;
        endcase
        rd_q.push_back(r);
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (((cyc <= m_end + 1) || !adc_cs_n) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: timeout after %0d cycles, required idle", n);
        end
    endtask

    // ---------------- read-data monitor ----------------
    always @(negedge clk) begin : mon_rd
        rd_t r;
        if (rd_q.size() > 0 && rd_q[0].at_edge == cyc) begin
            r = rd_q.pop_front();
            check($sformatf("read_addr%0d", r.a), readdata, r.exp);
        end
    end

    // ---------------- serial frame monitor ----------------
    bit          mon_en     = 1'b0;
    bit          abort_pend = 1'b0;
    logic        p_cs_n = 1'b1, p_sclk = 1'b0, p_sdi = 1'b0;
    logic [15:0] mon_sh;
    logic [15:0] mon_exp;
    int          mon_nbits = 0, mon_low = 0, mon_last_rise = -1;
    int          mon_rises_total = 0;
    int          viol = 0;

    always @(negedge clk) begin : mon_ser
        if (mon_en) begin
            if (p_cs_n && !adc_cs_n) begin
                check("frame_expected", 32'(exp_words.size() != 0), 32'd1);
                mon_sh = '0; mon_nbits = 0; mon_low = 0; mon_last_rise = -1;
            end
            if (!adc_cs_n) mon_low++;
            if (!p_sclk && adc_sclk) begin
                mon_rises_total++;
                if (adc_cs_n) viol++;
                mon_sh = {mon_sh[14:0], adc_sdi};
                mon_nbits++;
                if (mon_last_rise >= 0) check("sclk_period", 32'(cyc - mon_last_rise), 32'(2 * D));
                mon_last_rise = cyc;
            end
            // sdi may only move on a falling SCLK edge inside the frame
            if (!p_cs_n && !adc_cs_n && (adc_sdi != p_sdi) && !(p_sclk && !adc_sclk)) viol++;
            if (adc_cs_n && (adc_sdi || adc_sclk)) viol++;
            if (!p_cs_n && adc_cs_n) begin
                if (abort_pend) begin
                    abort_pend = 1'b0;
                end else if (exp_words.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL frame_word: got 0x%0h with no transfer required", mon_sh);
                end else begin
                    mon_exp = exp_words.pop_front();
                    check("frame_word", 32'(mon_sh), 32'(mon_exp));
                    check("frame_bits", 32'(mon_nbits), 32'(W));
                    check("frame_cs_low", 32'(mon_low), 32'(CSLOW));
                end
            end
        end
        p_cs_n = adc_cs_n; p_sclk = adc_sclk; p_sdi = adc_sdi;
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int r_before, n, op, k;
        int busy2, rises2, badper2, viol2, lastr2;
        logic [15:0] word2;
        logic ps2;

        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        address2 = '0; chipselect2 = 1'b0; write_n2 = 1'b1; writedata2 = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd0);
        check("rst_sdi", 32'(adc_sdi), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        for (int a = 0; a < 4; a++) bus_read(2'(a));

        // write with chipselect low is ignored
        bus_write(2'd0, 32'h0000_BEEF, 1'b0);
        bus_read(2'd0);
        bus_write(2'd2, 32'hFFFF_FFFF, 1'b1);
        bus_write(2'd3, 32'hFFFF_FFFF, 1'b1);
        bus_read(2'd2);
        bus_read(2'd3);
        // W1C while idle
        bus_write(2'd1, 32'h2, 1'b1);
        bus_read(2'd1);

        // directed frame, overrun write mid-transfer, busy polled through the end
        bus_write(2'd0, 32'h0000_A5C3, 1'b1);
        repeat (10) bus_read(2'd1);
        bus_write(2'd0, 32'h0000_1234, 1'b1);
        bus_read(2'd0);
        bus_read(2'd1);
        repeat (140) bus_read(2'd1);
        bus_write(2'd1, 32'h2, 1'b1);
        bus_read(2'd1);
        wait_idle();
        bus_read(2'd0);

        // randomized traffic
        for (int t = 0; t < 6; t++) begin
            wait_idle();
            bus_write(2'd0, $urandom, 1'b1);
            k = $urandom_range(20, 160);
            for (int i = 0; i < k; i++) begin
                op = $urandom_range(0, 9);
                case (op)
                    0, 1, 2, 3: bus_read(2'($urandom_range(0, 3)));
                    4:          bus_write(2'd0, $urandom, 1'b1);
                    5:          bus_write(2'd1, $urandom, 1'b1);
                    6:          bus_write(2'($urandom_range(2, 3)), $urandom, 1'b1);
                    7:          bus_write(2'd0, $urandom, 1'b0);
                    default:    @(negedge clk);
                endcase
            end
        end
        wait_idle();
        for (int a = 0; a < 4; a++) bus_read(2'(a));
        repeat (2) @(negedge clk);
        check("pending_reads", 32'(rd_q.size()), 32'd0);
        check("pending_frames", 32'(exp_words.size()), 32'd0);

        // reset during bit 7 of a frame
        r_before = mon_rises_total;
        bus_write(2'd0, 32'h0000_F00F, 1'b1);
        n = 0;
        while ((mon_rises_total - r_before) < 8 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit7", 32'(mon_rises_total - r_before), 32'd8);
        @(negedge clk);
        reset = 1'b1;
        abort_pend = !adc_cs_n;
        exp_words.delete();
        m_tx = '0; m_ovr = 1'b0; m_start = -1000; m_end = -1000;
        @(negedge clk);
        reset = 1'b0;
        check("abort_cs_n", 32'(adc_cs_n), 32'd1);
        check("abort_sclk", 32'(adc_sclk), 32'd0);
        check("abort_sdi", 32'(adc_sdi), 32'd0);
        r_before = mon_rises_total;
        bus_read(2'd1);
        bus_read(2'd0);
        repeat (100) @(negedge clk);
        check("abort_no_sclk", 32'(mon_rises_total - r_before), 32'd0);
        check("sdi_sclk_rules", 32'(viol), 32'd0);

        // CLK_DIV = 2 instance, all-ones word
        @(negedge clk);
        address2 = 2'd0; writedata2 = 32'h0000_FFFF; chipselect2 = 1'b1; write_n2 = 1'b0;
        @(negedge clk);
        write_n2 = 1'b1; chipselect2 = 1'b0; address2 = 2'd1;
        busy2 = 0; rises2 = 0; badper2 = 0; viol2 = 0; lastr2 = -1; word2 = '0; ps2 = sclk2;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (readdata2[0]) busy2++;
            if (sclk2 && !ps2) begin
                rises2++;
                word2 = {word2[14:0], sdi2};
                if (lastr2 >= 0 && (i - lastr2) != 2 * D2) badper2++;
                lastr2 = i;
            end
            if (cs2 && (sdi2 || sclk2)) viol2++;
            ps2 = sclk2;
        end
        check("div2_busy_cycles", 32'(busy2), 32'(BUSY2));
        check("div2_rises", 32'(rises2), 32'(W));
        check("div2_bad_periods", 32'(badper2), 32'd0);
        check("div2_word", 32'(word2), 32'h0000_FFFF);
        check("div2_idle_sdi", 32'(viol2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_ask2_adc_sdi_tx.md
CPU_ASK2_ADC_SDI_TX -- requirements
Module: cpu_ask2_adc_sdi_tx

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the SCLK half-period in clk cycles (legal range 2..255).
REQ-002 Parameter DATA_W, default 16, SHALL set the transmitted word width.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  registered read data.
REQ-010 adc_cs_n  output  1  ADC chip select, active low.
REQ-011 adc_sclk  output  1  ADC serial clock, idle low.
REQ-012 adc_sdi  output  1  serial data to the ADC, MSB first.

Function
REQ-013 A write SHALL occur when chipselect=1 and write_n=0; any other combination SHALL be ignored.
REQ-014 Register map SHALL be: addr0 = TXDATA (R/W, bits DATA_W-1:0); addr1 = STATUS (bit0 busy RO, bit1 overrun R/W1C); addr2/3 SHALL read 0 and ignore writes.
REQ-015 readdata SHALL register the addressed value every clock, giving 1-cycle read latency, with unused bits 0.
REQ-016 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-017 An addr0 write in IDLE during cycle N SHALL load the shift register and TXDATA, enter SETUP, and drive adc_cs_n=0, busy=1, and adc_sdi=MSB at N+1.
REQ-018 SETUP SHALL last CLK_DIV cycles with adc_sclk=0, then enter SHIFT.
REQ-019 In SHIFT, each bit SHALL be CLK_DIV cycles sclk high followed by CLK_DIV cycles sclk low; adc_sdi SHALL change only when sclk falls; DATA_W bits SHALL be sent.
REQ-020 After the last bit's low phase, HOLD SHALL keep adc_cs_n=0 and sclk=0 for CLK_DIV cycles; then adc_cs_n=1.
REQ-021 GAP SHALL keep adc_cs_n=1 for CLK_DIV cycles, then the FSM SHALL return to IDLE and busy SHALL clear.
REQ-022 busy SHALL be 1 for exactly CLK_DIV*(2*DATA_W+3) cycles per transfer (140 at defaults).
REQ-023 An addr0 write while busy SHALL NOT alter TXDATA or the transfer and SHALL set overrun.
REQ-024 Writing 1 to STATUS bit1 SHALL clear overrun; if a set and a clear occur in the same cycle, set SHALL win.
REQ-025 adc_sdi SHALL be 0 whenever adc_cs_n=1.
REQ-026 The half-period counter SHALL be CLK_DIV-wide-sufficient (8 bits) and the bit counter ceil(log2(DATA_W+1)) bits; neither SHALL wrap within a transfer.

Reset
REQ-027 On reset=1 at a clk edge: state=IDLE, adc_cs_n=1, adc_sclk=0, adc_sdi=0, TXDATA=0, busy=0, overrun=0, readdata=0.
REQ-028 Reset asserted mid-transfer SHALL abort at the next edge with no further SCLK pulse; no partial word SHALL resume after reset.

Structure
REQ-029 Register addresses, STATUS bit positions and the FSM state enumeration SHALL reside in shared package cpu_ask2_adc_pkg.
REQ-030 SCLK/bit timing SHALL be one sub-module, cpu_ask2_sclk_gen (half-period counter, rise/fall strobes); the FSM and register file SHALL stay in the top module.

Verification
REQ-031 Write 0xA5C3 to addr0 at defaults -> cs_n low next cycle, 16 SCLK rising edges sample 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, busy high for 140 cycles.
REQ-032 Second addr0 write of 0x1234 during busy -> waveform still 0xA5C3, TXDATA reads 0xA5C3, STATUS reads 0x3.
REQ-033 Write 0x2 to addr1 while idle -> STATUS reads 0x0; set and clear in the same cycle -> overrun remains 1.
REQ-034 Reset pulsed at SHIFT bit 7 -> next cycle cs_n=1, sclk=0, sdi=0, STATUS=0, no further SCLK edges.
REQ-035 CLK_DIV=2, write 0xFFFF -> SCLK period 4 clk, busy 70 cycles, sdi high only while cs_n low.
REQ-036 chipselect=0 with write_n=0 on addr0 -> no transfer, readdata of addr0 unchanged.
